// File: rtl/juice_vend_controller.sv
// Vend sequencer: coin credit accumulation, two-way juice selection onto one
// shared valve with done/timeout handshake, and $1 change-pulse refunds.
module juice_vend_controller #(
  parameter int PRICE_1      = 2,
  parameter int PRICE_2      = 3,
  parameter int MAX_CREDIT   = 9,
  parameter int DISP_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] dollar,
  input  logic       sel_1,
  input  logic       sel_2,
  input  logic       cancel,
  input  logic       disp_done,
  output logic       juice_1,
  output logic       juice_2,
  output logic       return_change,
  output logic [3:0] credit,
  output logic       coin_reject,
  output logic       fault,
  output logic       busy
);

  localparam int TW = $clog2(DISP_TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_CREDIT, S_DISPENSE, S_CHANGE} state_t;

  state_t        r_state, w_state_n;
  logic [3:0]    r_credit, w_credit_n;
  logic          r_juice_1, w_juice_1_n;
  logic          r_juice_2, w_juice_2_n;
  logic          r_change, w_change_n;
  logic          r_reject, w_reject_n;
  logic          r_fault, w_fault_n;
  logic          r_sel2, w_sel2_n;
  logic [TW-1:0] r_tcnt, w_tcnt_n;

  logic          w_coin;
  logic          w_coin_valid;
  logic [3:0]    w_coin_val;
  logic [4:0]    w_sum;
  logic          w_fits;

  assign w_coin = (dollar != 3'b000);

  always_comb begin
    w_coin_valid = 1'b1;
    w_coin_val   = '0;
    case (dollar)
      3'b001:  w_coin_val = 4'd1;
      3'b010:  w_coin_val = 4'd2;
      3'b011:  w_coin_val = 4'd5;
      default: w_coin_valid = 1'b0;
    endcase
  end

  assign w_sum  = {1'b0, r_credit} + {1'b0, w_coin_val};
  assign w_fits = w_coin_valid && (w_sum <= 5'(MAX_CREDIT));

  always_comb begin
    w_state_n   = r_state;
    w_credit_n  = r_credit;
    w_juice_1_n = r_juice_1;
    w_juice_2_n = r_juice_2;
    w_change_n  = 1'b0;
    w_reject_n  = 1'b0;
    w_fault_n   = 1'b0;
    w_sel2_n    = r_sel2;
    w_tcnt_n    = r_tcnt;

    case (r_state)
      S_IDLE, S_CREDIT: begin
        if (w_coin) begin
          if (w_fits) begin
            w_credit_n = w_sum[3:0];
            w_state_n  = S_CREDIT;
          end else begin
            w_reject_n = 1'b1;
          end
        end
        // Cancel wins over selection; a coin in the same cycle still lands.
        if (r_state == S_CREDIT) begin
          if (cancel) begin
            w_state_n  = S_CHANGE;
            w_change_n = 1'b1;
          end else if (!w_coin) begin
            if (sel_1) begin
              if (r_credit >= 4'(PRICE_1)) begin
                w_credit_n  = r_credit - 4'(PRICE_1);
                w_juice_1_n = 1'b1;
                w_sel2_n    = 1'b0;
                w_tcnt_n    = '0;
                w_state_n   = S_DISPENSE;
              end
            end else if (sel_2) begin
              if (r_credit >= 4'(PRICE_2)) begin
                w_credit_n  = r_credit - 4'(PRICE_2);
                w_juice_2_n = 1'b1;
                w_sel2_n    = 1'b1;
                w_tcnt_n    = '0;
                w_state_n   = S_DISPENSE;
              end
            end
          end
        end
      end

      S_DISPENSE: begin
        w_reject_n = w_coin;
        if (disp_done) begin
          w_juice_1_n = 1'b0;
          w_juice_2_n = 1'b0;
          if (r_credit != 4'd0) begin
            w_state_n  = S_CHANGE;
            w_change_n = 1'b1;
          end else begin
            w_state_n = S_IDLE;
          end
        end else if (r_tcnt == TW'(DISP_TIMEOUT - 1)) begin
          w_juice_1_n = 1'b0;
          w_juice_2_n = 1'b0;
          w_fault_n   = 1'b1;
          w_credit_n  = r_credit + (r_sel2 ? 4'(PRICE_2) : 4'(PRICE_1));
          w_state_n   = S_CHANGE;
          w_change_n  = 1'b1;
        end else begin
          w_tcnt_n = r_tcnt + 1'b1;
        end
      end

      S_CHANGE: begin
        w_reject_n = w_coin;
        // Each high pulse retires one dollar at its closing edge.
        if (r_change) begin
          w_credit_n = r_credit - 4'd1;
          if (r_credit == 4'd1) w_state_n = S_IDLE;
        end else begin
          w_change_n = 1'b1;
        end
      end

      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_credit  <= '0;
      r_juice_1 <= 1'b0;
      r_juice_2 <= 1'b0;
      r_change  <= 1'b0;
      r_reject  <= 1'b0;
      r_fault   <= 1'b0;
      r_sel2    <= 1'b0;
      r_tcnt    <= '0;
    end else begin
      r_state   <= w_state_n;
      r_credit  <= w_credit_n;
      r_juice_1 <= w_juice_1_n;
      r_juice_2 <= w_juice_2_n;
      r_change  <= w_change_n;
      r_reject  <= w_reject_n;
      r_fault   <= w_fault_n;
      r_sel2    <= w_sel2_n;
      r_tcnt    <= w_tcnt_n;
    end
  end

  assign juice_1       = r_juice_1;
  assign juice_2       = r_juice_2;
  assign return_change = r_change;
  assign credit        = r_credit;
  assign coin_reject   = r_reject;
  assign fault         = r_fault;
  assign busy          = (r_state == S_DISPENSE) || (r_state == S_CHANGE);

endmodule

// File: tb/tb_juice_vend_controller.sv
// Directed bench for juice_vend_controller; expected output vectors are queued
// as each cycle's stimulus is driven and compared after the following edge.
module tb_juice_vend_controller;

  logic       clk;
  logic       rst_n;
  logic [2:0] dollar;
  logic       sel_1, sel_2, cancel, disp_done;
  logic       juice_1, juice_2, return_change, coin_reject, fault, busy;
  logic [3:0] credit;

  typedef struct {
    string      tag;
    logic [9:0] v;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   errors;

  logic [9:0] w_obs;

  juice_vend_controller #(
    .PRICE_1     (2),
    .PRICE_2     (3),
    .MAX_CREDIT  (9),
    .DISP_TIMEOUT(16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .dollar       (dollar),
    .sel_1        (sel_1),
    .sel_2        (sel_2),
    .cancel       (cancel),
    .disp_done    (disp_done),
    .juice_1      (juice_1),
    .juice_2      (juice_2),
    .return_change(return_change),
    .credit       (credit),
    .coin_reject  (coin_reject),
    .fault        (fault),
    .busy         (busy)
  );

  assign w_obs = {juice_1, juice_2, return_change, credit, coin_reject, fault, busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running required=finished");
    $fatal(1, "time limit");
  end

  function automatic logic [9:0] ev(input logic j1, input logic j2, input logic rc,
                                    input logic [3:0] cr, input logic rej,
                                    input logic flt, input logic b);
    return {j1, j2, rc, cr, rej, flt, b};
  endfunction

  task automatic check();
    exp_t x;
    x = sb.pop_front();
    checks++;
    assert (w_obs === x.v) else begin
      errors++;
      $error("FAIL %s observed=%b required=%b", x.tag, w_obs, x.v);
    end
  endtask

  // Drive one cycle of stimulus, queue the expectation for the next cycle.
  task automatic cyc(input logic [2:0] d, input logic s1, input logic s2,
                     input logic can, input logic done,
                     input string tag, input logic [9:0] e);
    dollar    = d;
    sel_1     = s1;
    sel_2     = s2;
    cancel    = can;
    disp_done = done;
    sb.push_back('{tag, e});
    @(posedge clk);
    #1;
    dollar    = 3'b000;
    sel_1     = 1'b0;
    sel_2     = 1'b0;
    cancel    = 1'b0;
    disp_done = 1'b0;
    check();
  endtask

  localparam logic [2:0] NC = 3'b000;
  localparam logic [2:0] D1 = 3'b001;
  localparam logic [2:0] D2 = 3'b010;
  localparam logic [2:0] D5 = 3'b011;
  localparam logic [2:0] DX = 3'b111;

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    dollar    = NC;
    sel_1     = 1'b0;
    sel_2     = 1'b0;
    cancel    = 1'b0;
    disp_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sb.push_back('{"reset", ev(0,0,0,4'd0,0,0,0)});
    check();
    rst_n = 1'b1;

    // $1, $1, sel_1, dispense completed by disp_done
    cyc(D1, 0,0,0,0, "t1_coin1",   ev(0,0,0,4'd1,0,0,0));
    cyc(D1, 0,0,0,0, "t1_coin2",   ev(0,0,0,4'd2,0,0,0));
    cyc(NC, 1,0,0,0, "t1_sel1",    ev(1,0,0,4'd0,0,0,1));
    cyc(NC, 0,0,0,0, "t1_hold",    ev(1,0,0,4'd0,0,0,1));
    cyc(NC, 0,0,0,1, "t1_done",    ev(0,0,0,4'd0,0,0,0));
    cyc(NC, 0,0,0,1, "t1_idledone",ev(0,0,0,4'd0,0,0,0));

    // $5, sel_2, disp_done on third dispense cycle, two change pulses
    cyc(D5, 0,0,0,0, "t2_coin5",   ev(0,0,0,4'd5,0,0,0));
    cyc(NC, 0,1,0,0, "t2_sel2",    ev(0,1,0,4'd2,0,0,1));
    cyc(NC, 0,0,0,0, "t2_hold1",   ev(0,1,0,4'd2,0,0,1));
    cyc(NC, 0,0,0,0, "t2_hold2",   ev(0,1,0,4'd2,0,0,1));
    cyc(NC, 0,0,0,1, "t2_done",    ev(0,0,1,4'd2,0,0,1));
    cyc(NC, 0,0,0,0, "t2_gap1",    ev(0,0,0,4'd1,0,0,1));
    cyc(NC, 0,0,0,0, "t2_pulse2",  ev(0,0,1,4'd1,0,0,1));
    cyc(NC, 0,0,0,0, "t2_idle",    ev(0,0,0,4'd0,0,0,0));

    // ceiling and invalid code rejects
    cyc(D5, 0,0,0,0, "t3_coin5",   ev(0,0,0,4'd5,0,0,0));
    cyc(D5, 0,0,0,0, "t3_over",    ev(0,0,0,4'd5,1,0,0));
    cyc(DX, 0,0,0,0, "t3_invalid", ev(0,0,0,4'd5,1,0,0));
    cyc(NC, 0,0,0,0, "t3_quiet",   ev(0,0,0,4'd5,0,0,0));

    // both selections: juice_1 wins; then refund of 3
    cyc(NC, 1,1,0,0, "t4_both",    ev(1,0,0,4'd3,0,0,1));
    cyc(NC, 0,0,0,1, "t4_done",    ev(0,0,1,4'd3,0,0,1));
    cyc(NC, 0,0,0,0, "t4_c1",      ev(0,0,0,4'd2,0,0,1));
    cyc(NC, 0,0,0,0, "t4_c2",      ev(0,0,1,4'd2,0,0,1));
    cyc(NC, 0,0,0,0, "t4_c3",      ev(0,0,0,4'd1,0,0,1));
    cyc(NC, 0,0,0,0, "t4_c4",      ev(0,0,1,4'd1,0,0,1));
    cyc(NC, 0,0,0,0, "t4_idle",    ev(0,0,0,4'd0,0,0,0));
    cyc(D1, 0,0,0,0, "t4_coin1",   ev(0,0,0,4'd1,0,0,0));
    cyc(NC, 0,1,0,0, "t4_poor",    ev(0,0,0,4'd1,0,0,0));
    cyc(D1, 1,0,0,0, "t4_coinsel", ev(0,0,0,4'd2,0,0,0));

    // dispense timeout with a coin rejected mid-dispense, then refund of 3
    cyc(D1, 0,0,0,0, "t5_coin",    ev(0,0,0,4'd3,0,0,0));
    cyc(NC, 1,0,0,0, "t5_sel1",    ev(1,0,0,4'd1,0,0,1));
    for (int unsigned i = 1; i <= 15; i++)
      cyc((i == 5) ? D1 : NC, 0,0,0,0, $sformatf("t5_hold%0d", i),
          ev(1,0,0,4'd1,(i == 5),0,1));
    cyc(NC, 0,0,0,0, "t5_fault",   ev(0,0,1,4'd3,0,1,1));
    cyc(NC, 0,0,0,0, "t5_c1",      ev(0,0,0,4'd2,0,0,1));
    cyc(NC, 0,0,0,0, "t5_c2",      ev(0,0,1,4'd2,0,0,1));
    cyc(NC, 0,0,0,0, "t5_c3",      ev(0,0,0,4'd1,0,0,1));
    cyc(NC, 0,0,0,0, "t5_c4",      ev(0,0,1,4'd1,0,0,1));
    cyc(NC, 0,0,0,0, "t5_idle",    ev(0,0,0,4'd0,0,0,0));

    // exact ceiling accepted, one more rejected, cancel refunds 9
    cyc(D5, 0,0,0,0, "t6_c5",      ev(0,0,0,4'd5,0,0,0));
    cyc(D2, 0,0,0,0, "t6_c7",      ev(0,0,0,4'd7,0,0,0));
    cyc(D2, 0,0,0,0, "t6_c9",      ev(0,0,0,4'd9,0,0,0));
    cyc(D1, 0,0,0,0, "t6_over",    ev(0,0,0,4'd9,1,0,0));
    cyc(NC, 0,0,1,0, "t6_cancel",  ev(0,0,1,4'd9,0,0,1));
    for (int unsigned c = 9; c >= 1; c--) begin
      cyc(NC, 0,0,0,0, $sformatf("t6_low%0d", c), ev(0,0,0,4'(c - 1),0,0,(c > 1)));
      if (c > 1)
        cyc(NC, 0,0,0,0, $sformatf("t6_high%0d", c), ev(0,0,1,4'(c - 1),0,0,1));
    end

    // cancel with 4, reset asserted during the second change pulse
    cyc(D2, 0,0,0,0, "t7_c2",      ev(0,0,0,4'd2,0,0,0));
    cyc(D2, 0,0,0,0, "t7_c4",      ev(0,0,0,4'd4,0,0,0));
    cyc(NC, 0,0,1,0, "t7_cancel",  ev(0,0,1,4'd4,0,0,1));
    cyc(NC, 0,0,0,0, "t7_gap",     ev(0,0,0,4'd3,0,0,1));
    cyc(NC, 0,0,0,0, "t7_pulse2",  ev(0,0,1,4'd3,0,0,1));
    rst_n = 1'b0;
    sb.push_back('{"t7_async_rst", ev(0,0,0,4'd0,0,0,0)});
    #1;
    check();
    sb.push_back('{"t7_rst_held", ev(0,0,0,4'd0,0,0,0)});
    @(posedge clk);
    #1;
    check();
    rst_n = 1'b1;
    cyc(NC, 0,0,0,0, "t7_after",   ev(0,0,0,4'd0,0,0,0));
    cyc(D1, 0,0,0,0, "t7_restart", ev(0,0,0,4'd1,0,0,0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/juice_vend_controller.md
# juice_vend_controller

Top-level vend sequencer for the juice machine. Accepts coin codes, accumulates credit, and arbitrates two juice selection requests onto a single shared dispense valve with a done/timeout handshake. Returns leftover credit as a train of $1 change pulses. Sits between the coin acceptor/front panel and the dispense valve and change hopper.

## Interface
- PRICE_1, 2: price of juice 1 in dollars.
- PRICE_2, 3: price of juice 2 in dollars.
- MAX_CREDIT, 9: credit ceiling in dollars (≤15).
- DISP_TIMEOUT, 16: cycles to wait for disp_done before faulting (≥2).
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- dollar  in  3  coin code each cycle: 3'b001=$1, 3'b010=$2, 3'b011=$5, 3'b000=no coin, others=invalid (rejected).
- sel_1  in  1  one-cycle request for juice 1.
- sel_2  in  1  one-cycle request for juice 2.
- cancel  in  1  one-cycle request to refund all credit.
- disp_done  in  1  valve completion strobe.
- juice_1  out  1  dispense request, juice 1 (level).
- juice_2  out  1  dispense request, juice 2 (level).
- return_change  out  1  one-cycle pulse = one $1 returned.
- credit  out  4  current credit in dollars.
- coin_reject  out  1  one-cycle pulse: coin not accepted.
- fault  out  1  one-cycle pulse: dispense timeout.
- busy  out  1  high in DISPENSE or CHANGE.

## Operation
- States: IDLE (credit=0), CREDIT, DISPENSE, CHANGE.
- Reset: state IDLE, credit 0, all outputs 0, timeout counter 0.
- Coin (dollar≠000) in IDLE/CREDIT: valid code and credit+value ≤ MAX_CREDIT → credit += value, IDLE→CREDIT. Otherwise coin_reject pulses and credit is unchanged.
- Any nonzero dollar in DISPENSE/CHANGE → coin_reject; credit unchanged.
- Selection in CREDIT, no coin that cycle: sel_1 has fixed priority over sel_2. Winner with credit ≥ its price → credit -= price, enter DISPENSE, assert juice_x. Insufficient credit → request dropped, state held.
- Coin and selection in the same cycle: coin processed, selection dropped.
- cancel in CREDIT (takes priority over selection, coin still processed) → CHANGE. cancel ignored elsewhere.
- DISPENSE: juice_x held high. disp_done sampled high → juice_x low next edge; go to CHANGE if credit>0, else IDLE.
- Timeout: counter counts cycles in DISPENSE. Reaching DISP_TIMEOUT without disp_done → juice_x low, credit += price (refund), fault pulse, → CHANGE.
- CHANGE: return_change alternates high/low starting high on the first CHANGE cycle. Each high cycle decrements credit by 1 at its closing edge. The edge that brings credit to 0 → IDLE.
- Arithmetic: credit is 4-bit unsigned. Ceiling checks prevent overflow, and price checks prevent underflow.
- busy = (state==DISPENSE || state==CHANGE).

## Timing
- Coin at cycle N → credit updated and visible in N+1. coin_reject pulses in N+1.
- Selection accepted at N → juice_x=1 and reduced credit in N+1.
- disp_done at M → juice_x=0 in M+1. First return_change in M+1 if credit>0.
- Refund of credit C: return_change high in cycles k, k+2, …, k+2(C−1). State is IDLE at k+2C−1.
- Timeout: juice_x high for exactly DISP_TIMEOUT cycles. fault pulses in the following cycle.
- disp_done outside DISPENSE is ignored.
- rst_n low at any time, including mid-dispense or mid-change: immediate IDLE, outputs 0, credit lost.

## Test plan
- Reset, then $1,$1 in consecutive cycles, sel_1 → credit 1,2,0. juice_1 high until disp_done. No return_change. IDLE.
- $5 then sel_2, disp_done after 3 cycles → juice_2 high 3 cycles, credit 2, then 2 return_change pulses one cycle apart. credit 0, IDLE.
- $5,$5 → second coin rejected (coin_reject=1), credit stays 5. Invalid code 3'b111 also rejected.
- Credit 5, sel_1 and sel_2 same cycle → juice_1 wins, credit 3. Credit 1 with sel_2 → ignored, credit stays 1.
- Credit 3, sel_1, disp_done never arrives → juice_1 high DISP_TIMEOUT cycles, fault pulse, credit back to 3, 3 change pulses.
- Credit 4, cancel → 4 change pulses. Assert rst_n low during the 2nd pulse → all outputs 0, credit 0 immediately.
